// File: rtl/fc_act_mem.sv
// fc_act_mem: ping-pong activation memory for the FC stack.
// The host streams layer-0 inputs into the read bank, the FC stack reads one
// bank while writing the other, and the final bank drains over a stream.
// Optional build macro FC_ACT_RELU_EN: clamp negative FC writes to zero on capture.
module fc_act_mem #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 64,
    parameter int FRT_CELL = 32,
    parameter int BCK_CELL = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic signed [DATA_W-1:0] load_data,
    output logic                     fc_enable,
    input  logic                     fc_we,
    input  logic [15:0]              fc_addr,
    input  logic signed [DATA_W-1:0] fc_data,
    output logic signed [DATA_W-1:0] fc_rdata,
    input  logic                     layer_end,
    input  logic                     all_end,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy
);

    localparam int            AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0]   DEPTH_A    = 16'(DEPTH);
    localparam logic [AW-1:0] LOAD_LAST  = AW'(FRT_CELL - 1);
    localparam logic [AW-1:0] DRAIN_LAST = AW'(BCK_CELL - 1);
    localparam logic [AW-1:0] CNT_ONE    = AW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic                     rd_bank, wr_bank, drain_bank;
    logic [AW-1:0]            load_cnt, drain_cnt;
    logic                     layer_q, all_q;
    logic                     layer_rise, all_rise;
    logic                     load_fire, drain_fire;
    logic                     addr_ok;
    logic [AW-1:0]            fc_idx;
    logic signed [DATA_W-1:0] mem [2][DEPTH];

    // Capture transform applied to FC write data only; host loads bypass it.
    function automatic logic signed [DATA_W-1:0] relu_capture(input logic signed [DATA_W-1:0] d);
`ifdef FC_ACT_RELU_EN
        return d[DATA_W-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    assign layer_rise = layer_end & ~layer_q;
    assign all_rise   = all_end & ~all_q;
    assign load_fire  = load_valid & load_ready;
    assign drain_fire = out_valid & out_ready;
    assign addr_ok    = (fc_addr < DEPTH_A);
    assign fc_idx     = fc_addr[AW-1:0];
    assign busy       = (state_q != IDLE);
    // Drain bank is static during DRAIN, so the combinational read holds under stall.
    assign out_data   = out_valid ? mem[drain_bank][drain_cnt] : '0;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and per-state stream/enable outputs.
    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        fc_enable  = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid && load_cnt == LOAD_LAST) state_d = RUN;
            end
            RUN: begin
                fc_enable = 1'b1;
                if (all_rise) state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && drain_cnt == DRAIN_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bank selects, counters and edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_bank    <= 1'b0;
            wr_bank    <= 1'b1;
            drain_bank <= 1'b0;
            load_cnt   <= '0;
            drain_cnt  <= '0;
            layer_q    <= 1'b0;
            all_q      <= 1'b0;
        end else begin
            layer_q <= layer_end;
            all_q   <= all_end;
            case (state_q)
                IDLE: begin
                    rd_bank   <= 1'b0;
                    wr_bank   <= 1'b1;
                    load_cnt  <= '0;
                    drain_cnt <= '0;
                end
                LOAD: if (load_fire) load_cnt <= load_cnt + CNT_ONE;
                RUN: begin
                    if (layer_rise) begin
                        rd_bank <= wr_bank;
                        wr_bank <= rd_bank;
                    end
                    // On a coincident swap the post-swap write bank is the old read bank.
                    if (all_rise) drain_bank <= layer_rise ? rd_bank : wr_bank;
                end
                DRAIN: begin
                    if (drain_fire) begin
                        if (drain_cnt == DRAIN_LAST) begin
                            drain_cnt <= '0;
                            load_cnt  <= '0;
                            rd_bank   <= 1'b0;
                            wr_bank   <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Bank writes: host loads into the read bank, FC results into the write bank.
    always_ff @(posedge clk) begin
        if (load_fire)
            mem[rd_bank][load_cnt] <= load_data;
        else if (state_q == RUN && fc_we && addr_ok)
            mem[wr_bank][fc_idx] <= relu_capture(fc_data);
    end

    // One-cycle read port from the read bank, live in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        fc_rdata <= '0;
        else if (addr_ok) fc_rdata <= mem[rd_bank][fc_idx];
        else              fc_rdata <= '0;
    end

endmodule

// File: tb/tb_fc_act_mem.sv
// Scoreboard bench for fc_act_mem: stimulus pushes expected read data and
// drain words into queues; monitors pop and compare when the DUT presents them.
module tb_fc_act_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic        fc_enable;
    logic        fc_we = 1'b0;
    logic [15:0] fc_addr = '0;
    logic [15:0] fc_data = '0;
    logic [15:0] fc_rdata;
    logic        layer_end = 1'b0;
    logic        all_end = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_rd_q[$];
    logic [15:0] exp_out_q[$];
    logic        rd_req = 1'b0;
    logic        rd_take;

`ifdef FC_ACT_RELU_EN
    localparam logic [15:0] RELU_EXP = 16'h0000;
`else
    localparam logic [15:0] RELU_EXP = 16'hFFF0;
`endif

    fc_act_mem #(.DATA_W(16), .DEPTH(64), .FRT_CELL(32), .BCK_CELL(10)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .fc_enable(fc_enable), .fc_we(fc_we), .fc_addr(fc_addr), .fc_data(fc_data),
        .fc_rdata(fc_rdata), .layer_end(layer_end), .all_end(all_end),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read monitor: a request present at the edge is checked just after it.
    always @(posedge clk) begin
        rd_take = rd_req;
        #1;
        if (rd_take) begin
            if (exp_rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_underflow: got %h expected none", fc_rdata);
            end else begin
                chk16("fc_rdata", fc_rdata, exp_rd_q.pop_front());
            end
        end
    end

    // Drain monitor: sampled just before the edge; stalls must hold the head word.
    always @(negedge clk) begin
        #4;
        if (out_valid) begin
            if (exp_out_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_unexpected: got %h expected none", out_data);
            end else if (out_ready) begin
                chk16("out_beat", out_data, exp_out_q.pop_front());
            end else begin
                chk16("out_hold", out_data, exp_out_q[0]);
            end
        end
    end

    task automatic do_load(input int base);
        for (int i = 0; i < 32; i++) begin
            load_valid = 1'b1;
            load_data  = 16'(base + i);
            chk1("load_ready_beat", load_ready, 1'b1);
            @(negedge clk);
        end
        load_valid = 1'b0;
        chk1("load_ready_after", load_ready, 1'b0);
        chk1("fc_enable_run", fc_enable, 1'b1);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] exp);
        fc_we   = 1'b0;
        fc_addr = addr;
        rd_req  = 1'b1;
        exp_rd_q.push_back(exp);
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        rd_req  = 1'b0;
        fc_we   = 1'b1;
        fc_addr = addr;
        fc_data = data;
        @(negedge clk);
        fc_we   = 1'b0;
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        chk1("rst_load_ready", load_ready, 1'b0);
        chk1("rst_fc_enable", fc_enable, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk16("rst_fc_rdata", fc_rdata, 16'h0000);
        chk16("rst_out_data", out_data, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        chk1("load_entry_busy", busy, 1'b1);
        chk1("load_entry_ready", load_ready, 1'b1);

        // T2: 32 words 1..32 into bank 0
        do_load(1);

        // T3: reads with one-cycle latency, out-of-range returns 0
        rd(16'd5, 16'd6);
        rd(16'd70, 16'd0);
        rd(16'd0, 16'd1);
        rd(16'd31, 16'd32);

        // T4: writes to bank 1, out-of-range write dropped, write on swap edge
        wr(16'd3, 16'h0042);
        wr(16'd6, 16'h0077);
        wr(16'd70, 16'h1234);
        fc_we = 1'b1; fc_addr = 16'd0; fc_data = 16'h0100; layer_end = 1'b1;
        @(negedge clk);
        fc_we = 1'b0;
        rd(16'd3, 16'h0042);
        rd(16'd6, 16'h0077);
        rd(16'd0, 16'h0100);
        rd(16'd70, 16'h0000);

        // T6: negative FC write into bank 0, swap back, read it
        wr(16'd9, 16'hFFF0);
        wr(16'd10, 16'h7FFF);
        layer_end = 1'b0;
        @(negedge clk);
        layer_end = 1'b1;
        @(negedge clk);
        layer_end = 1'b0;
        rd(16'd9, RELU_EXP);
        rd(16'd10, 16'h7FFF);
        rd(16'd5, 16'd6);

        // T5 setup: bank 1 gets results, swap, bank 0 gets decoys
        for (int i = 0; i < 10; i++) wr(16'(i), 16'(16'h0A00 + i));
        layer_end = 1'b1;
        @(negedge clk);
        layer_end = 1'b0;
        rd(16'd4, 16'h0A04);
        for (int i = 0; i < 10; i++) wr(16'(i), 16'(16'h0B00 + i));

        // Coincident layer_end/all_end: swap first, drain post-swap write bank (bank 1)
        for (int i = 0; i < 10; i++) exp_out_q.push_back(16'(16'h0A00 + i));
        layer_end = 1'b1; all_end = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk1("drain_fc_enable", fc_enable, 1'b0);
        chk1("drain_out_valid", out_valid, 1'b1);
        n = 0;
        while (exp_out_q.size() > 0 && n < 100) begin
            out_ready = n[0];
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_out_q.size());
        end
        out_ready = 1'b0; layer_end = 1'b0; all_end = 1'b0;
        chk1("drain_done_valid", out_valid, 1'b0);
        chk1("drain_done_idle", busy, 1'b0);
        @(negedge clk);
        chk1("reload_busy", busy, 1'b1);
        chk1("reload_ready", load_ready, 1'b1);

        // T1: second pass, then reset mid-DRAIN
        do_load(100);
        rd(16'd5, 16'd105);
        exp_out_q.push_back(16'h0A00);
        all_end = 1'b1;
        @(negedge clk);
        chk1("drain2_out_valid", out_valid, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #2;
        exp_out_q.delete();
        reset = 1'b1;
        #1;
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_fc_enable", fc_enable, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk16("abort_out_data", out_data, 16'h0000);
        @(negedge clk);
        reset = 1'b0; all_end = 1'b0;
        @(negedge clk);
        chk1("abort_reload_ready", load_ready, 1'b1);
        chk1("abort_reload_busy", busy, 1'b1);
        @(negedge clk);

        if (exp_rd_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL rd_leftover: got %0d expected 0", exp_rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
